seg_scan_disp: RTL and testbench
================================

Name: seg_scan_disp

Overview:
- Downstream display stage for the 4-bit synchronous counter output.
- Samples the counter value (0..15) into the clk domain and splits it into two decimal digits.
- Time-multiplexes both digits onto one shared 7-segment bus with one-hot digit enables.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 4, clk cycles each digit stays selected; legal range 1..1023.
- PRE_W, 10, prescaler counter width; must hold SCAN_DIV-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- val_in  input  4  counter value; may change at any clk edge.
- seg  output  7  segments active-high; bit0=a ... bit6=g.
- dig_en  output  2  one-hot digit enable; bit0=ones digit, bit1=tens digit.
- upd  output  1  one-cycle pulse when the displayed value changes.

Behaviour:
- Reset: one clock (clk); asynchronous active-low reset (rst); every register clears immediately, including mid-operation.
  - Reset values: s1=s2=disp_val=0, pre=0, sel=0, seg=7'h00, dig_en=2'b00, upd=0.
- Sync/filter stage: s1<=val_in; s2<=s1.
  - When s1==s2 and s2!=disp_val: disp_val<=s2 and upd<=1 for one cycle; otherwise upd<=0.
  - A value held on val_in for only one clk edge is never latched.
  - Latency: disp_val takes the new value at the 3rd posedge after val_in settles; upd is high for the cycle after that edge.
- Digit split:
  - disp_val>=10: tens=1, ones=disp_val-10.
  - Otherwise: tens=0, ones=disp_val.
  - 4-bit arithmetic only; no value above 15 exists.
- Prescaler: pre increments each cycle.
  - At pre==SCAN_DIV-1, pre wraps to 0 and sel toggles.
  - SCAN_DIV=1 toggles sel every cycle.
- Output register, one cycle behind sel:
  - sel=0: dig_en<=2'b01, seg<=enc(ones).
  - sel=1: dig_en<=2'b10, seg<=enc(tens).
- After reset release, the first posedge drives dig_en=2'b01, seg=7'h3F.
- Encoding enc(d) for d=0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Simultaneous events: if disp_val updates in the same cycle sel toggles, the next seg uses the new disp_val. No cycle ever shows mixed old and new digits on one enable.
- dig_en is never 2'b11. It is 2'b00 only during and immediately after reset.

Optional Feature:
- Macro: SEG_LEAD_BLANK_EN.
- Defined: when sel=1 and tens==0, seg<=7'h00 (leading zero blanked); dig_en still 2'b10.
- Undefined: tens digit 0 shows 7'h3F.

Decomposition:
- Package seg_pkg holds:
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK.
  - DIG_ONES/DIG_TENS enable constants.
  - Default SCAN_DIV value.
- Sub-module seg_dec: combinational 4-bit digit to 7-bit segment lookup using seg_pkg constants; inputs 10..15 give SEG_BLANK.
- Instantiated once, fed by the sel-muxed digit.

Test Plan:
- Reset then val_in=0, SCAN_DIV=4, macro off -> dig_en toggles every 4 cycles.
  - dig_en 01 for 4 cycles, 10 for 4 cycles, repeating; seg=3F throughout; upd never pulses.
- val_in 0->7 held -> disp_val=7 on 3rd edge; upd high exactly 1 cycle.
  - Ones slots show seg=07; tens slots show 3F.
- val_in=13 -> ones slots seg=4F, tens slots seg=06.
  - val_in 15 then 0 (counter wrap) -> 6D/06, then 3F/3F; one upd per change.
- 1-cycle glitch val_in 5->9->5 with disp_val=5 -> no upd; seg never shows 6F.
- Assert rst low mid-frame with val_in=12 -> seg=00, dig_en=00, upd=0 immediately.
  - After release, value reappears 3 edges later with upd pulse.
- SEG_LEAD_BLANK_EN defined, val_in=4 -> tens slot seg=00, ones slot seg=66.
  - val_in=10 -> tens=06, ones=3F.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display stage.
// Segment bit order: bit0=a ... bit6=g, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_OFF  = 2'b00;
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  localparam int SCAN_DIV_DEF = 4;

endpackage

// File: rtl/seg_dec.sv
// Combinational decimal digit to 7-segment lookup.
// Codes 10..15 are not decimal digits and render as blank.
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Digit-to-segment table lookup
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_disp.sv
// Two-digit time-multiplexed 7-segment driver for a 4-bit counter value.
// The input is double-sampled and only accepted once two consecutive
// samples agree, so single-cycle glitches never reach the display.
// Optional build macro: SEG_LEAD_BLANK_EN blanks a leading zero tens digit.
module seg_scan_disp
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int PRE_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val_in,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       upd
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       disp_val;
  logic [PRE_W-1:0] pre;
  logic             sel;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_next;

  // Two-stage sampler; accept a value only when both stages agree
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= 4'd0;
      s2       <= 4'd0;
      disp_val <= 4'd0;
      upd      <= 1'b0;
    end else begin
      s1 <= val_in;
      s2 <= s1;
      if ((s1 == s2) && (s2 != disp_val)) begin
        disp_val <= s2;
        upd      <= 1'b1;
      end else begin
        upd      <= 1'b0;
      end
    end
  end

  // Scan prescaler: hold each digit for SCAN_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      sel <= 1'b0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      sel <= ~sel;
    end else begin
      pre <= pre + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Split the value into tens/ones and pick the digit for the active slot
  always_comb begin
    tens      = 4'd0;
    ones      = disp_val;
    cur_digit = 4'd0;
    if (disp_val >= 4'd10) begin
      tens = 4'd1;
      ones = disp_val - 4'd10;
    end else begin
      tens = 4'd0;
      ones = disp_val;
    end
    if (sel) begin
      cur_digit = tens;
    end else begin
      cur_digit = ones;
    end
  end

  seg_dec u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Optional leading-zero blanking on the tens slot
  always_comb begin
    seg_next = dec_seg;
`ifdef SEG_LEAD_BLANK_EN
    if (sel && (tens == 4'd0)) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = dec_seg;
    end
`else
    seg_next = dec_seg;
`endif
  end

  // Output register: enable and segments always change together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg    <= SEG_BLANK;
      dig_en <= DIG_OFF;
    end else begin
      seg    <= seg_next;
      dig_en <= sel ? DIG_TENS : DIG_ONES;
    end
  end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Self-checking bench for seg_scan_disp (SCAN_DIV=4).
// Honors SEG_LEAD_BLANK_EN when defined for the build.
module tb_seg_scan_disp;

  logic       clk;
  logic       rst;
  logic [3:0] val_in;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       upd;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] val;
    logic [6:0] ones;
    logic [6:0] tens;
  } vec_t;

  typedef struct packed {
    logic [6:0] ones;
    logic [6:0] tens;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];

  seg_scan_disp #(.SCAN_DIV(4), .PRE_W(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .val_in (val_in),
    .seg    (seg),
    .dig_en (dig_en),
    .upd    (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] tens_exp(input logic [6:0] t);
`ifdef SEG_LEAD_BLANK_EN
    return (t == 7'h3F) ? 7'h00 : t;
`else
    return t;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the update pulse, pop the expected digits, then watch two scan periods
  task automatic wait_upd_and_scan();
    int   edges;
    bit   seen;
    bit   saw_ones;
    bit   saw_tens;
    exp_t e;
    edges    = 0;
    seen     = 1'b0;
    saw_ones = 1'b0;
    saw_tens = 1'b0;
    while (!seen && edges < 6) begin
      tick();
      edges++;
      if (upd === 1'b1) seen = 1'b1;
    end
    chk("upd_latency", 8'(edges), 8'd3);
    e = sb_q.pop_front();
    tick();
    chk("upd_width", {7'd0, upd}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (dig_en === 2'b01) begin
        saw_ones = 1'b1;
        chk("seg_ones", {1'b0, seg}, {1'b0, e.ones});
      end else if (dig_en === 2'b10) begin
        saw_tens = 1'b1;
        chk("seg_tens", {1'b0, seg}, {1'b0, e.tens});
      end else begin
        chk("dig_en_onehot", {6'd0, dig_en}, 8'd1);
      end
      chk("upd_quiet", {7'd0, upd}, 8'd0);
      tick();
    end
    chk("both_slots", {6'd0, saw_ones, saw_tens}, 8'd3);
  endtask

  initial begin
    vecs[0] = '{val: 4'd7,  ones: 7'h07, tens: 7'h3F};
    vecs[1] = '{val: 4'd13, ones: 7'h4F, tens: 7'h06};
    vecs[2] = '{val: 4'd15, ones: 7'h6D, tens: 7'h06};
    vecs[3] = '{val: 4'd0,  ones: 7'h3F, tens: 7'h3F};
    vecs[4] = '{val: 4'd4,  ones: 7'h66, tens: 7'h3F};
    vecs[5] = '{val: 4'd10, ones: 7'h3F, tens: 7'h06};
    vecs[6] = '{val: 4'd9,  ones: 7'h6F, tens: 7'h3F};
    vecs[7] = '{val: 4'd12, ones: 7'h5B, tens: 7'h06};
    vecs[8] = '{val: 4'd5,  ones: 7'h6D, tens: 7'h3F};

    rst    = 1'b0;
    val_in = 4'd0;
    #12;
    chk("rst_seg",    {1'b0, seg},    8'h00);
    chk("rst_dig_en", {6'd0, dig_en}, 8'h00);
    chk("rst_upd",    {7'd0, upd},    8'h00);

    // Release away from the edge, then check the idle scan cadence
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("idle_dig_en", {6'd0, dig_en}, ((((n - 1) / 4) % 2) == 1) ? 8'd2 : 8'd1);
      chk("idle_seg", {1'b0, seg}, {1'b0, (((((n - 1) / 4) % 2) == 1) ? tens_exp(7'h3F) : 7'h3F)});
      chk("idle_upd", {7'd0, upd}, 8'd0);
    end

    // Table-driven value changes
    for (int v = 0; v < 9; v++) begin
      val_in = vecs[v].val;
      sb_q.push_back('{ones: vecs[v].ones, tens: tens_exp(vecs[v].tens)});
      wait_upd_and_scan();
    end

    // One-cycle glitch 5 -> 9 -> 5 must not be accepted
    val_in = 4'd9;
    tick();
    val_in = 4'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_upd", {7'd0, upd}, 8'd0);
      chk("glitch_no_9", {7'd0, (seg === 7'h6F)}, 8'd0);
    end

    // Settle on 12, then reset mid-frame
    val_in = 4'd12;
    sb_q.push_back('{ones: 7'h5B, tens: 7'h06});
    wait_upd_and_scan();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_seg",    {1'b0, seg},    8'h00);
    chk("midrst_dig_en", {6'd0, dig_en}, 8'h00);
    chk("midrst_upd",    {7'd0, upd},    8'h00);
    tick();
    chk("midrst_hold", {6'd0, dig_en}, 8'h00);
    rst = 1'b1;
    tick();
    chk("post_rst_dig_en", {6'd0, dig_en}, 8'h01);
    chk("post_rst_seg",    {1'b0, seg},    8'h3F);
    chk("post_rst_upd",    {7'd0, upd},    8'h00);
    // Two more edges bring the filtered value back; first edge already taken
    sb_q.push_back('{ones: 7'h5B, tens: 7'h06});
    tick();
    chk("post_rst_upd2", {7'd0, upd}, 8'h00);
    tick();
    chk("post_rst_upd3", {7'd0, upd}, 8'h01);
    begin
      exp_t e;
      e = sb_q.pop_front();
      tick();
      chk("post_rst_width", {7'd0, upd}, 8'h00);
      for (int i = 0; i < 8; i++) begin
        if (dig_en === 2'b10) chk("post_rst_tens", {1'b0, seg}, {1'b0, e.tens});
        else chk("post_rst_ones", {1'b0, seg}, {1'b0, e.ones});
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
